// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcodes, stage3 FSM states and the op payload.
package cpu_pkg;

    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned REG_IDX_W = 9;

    localparam logic [7:0] OPCODE_READRAM8   = 8'd1;
    localparam logic [7:0] OPCODE_JUMPMINUS  = 8'd2;

    typedef enum logic [1:0] {
        S3_IDLE = 2'd0,
        S3_REQ  = 2'd1,
        S3_WB   = 2'd2
    } stage3_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]    address;
        logic [REG_IDX_W-1:0] dest_reg;
    } op_t;

endpackage

// File: rtl/stage3_op_buf.sv
// Two-slot op holder for stage3: an active op being serviced plus one pending op.
module stage3_op_buf
    import cpu_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  op_t  op_i,
    input  logic pop_i,
    output logic accept_o,
    output op_t  act_op_o,
    output logic pend_valid_o
);

    logic act_v_q, act_v_d;
    logic pend_v_q, pend_v_d;
    op_t  act_q, act_d;
    op_t  pend_q, pend_d;

    // A completing active slot is refilled from pending first, else straight from the input.
    always_comb begin
        act_v_d  = act_v_q;
        pend_v_d = pend_v_q;
        act_d    = act_q;
        pend_d   = pend_q;
        if (pop_i) begin
            if (pend_v_q) begin
                act_d    = pend_q;
                pend_v_d = 1'b0;
            end else if (push_i) begin
                act_d = op_i;
            end else begin
                act_v_d = 1'b0;
            end
        end else if (push_i) begin
            if (!act_v_q) begin
                act_d   = op_i;
                act_v_d = 1'b1;
            end else begin
                pend_d   = op_i;
                pend_v_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            act_v_q  <= 1'b0;
            pend_v_q <= 1'b0;
            act_q    <= '0;
            pend_q   <= '0;
        end else begin
            act_v_q  <= act_v_d;
            pend_v_q <= pend_v_d;
            act_q    <= act_d;
            pend_q   <= pend_d;
        end
    end

    assign accept_o     = !pend_v_q;
    assign act_op_o     = act_q;
    assign pend_valid_o = pend_v_q;

endmodule

// File: rtl/stage3_mem.sv
// Memory-read stage: issues READRAM8 reads to the RAM arbiter and writes the byte to the regfile.
// Optional STAGE3_MEM_TIMEOUT_EN abandons a read after TIMEOUT_CYCLES and sets a sticky error.
module stage3_mem
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                 ram_clk,
    input  logic                 rst,
    input  logic                 stage3_read,
    input  logic [ADDR_W-1:0]    stage3_read_address,
    input  logic [REG_IDX_W-1:0] stage3_dest_reg,
    output logic                 stage3_accept,
    output logic                 stage3_ram_read,
    output logic [ADDR_W-1:0]    stage3_ram_read_address,
    input  logic                 stage3_ram_read_ready,
    input  logic [DATA_W-1:0]    stage3_ram_read_data_out,
    output logic                 reg_write_en,
    output logic [REG_IDX_W-1:0] reg_write_addr,
    output logic [DATA_W-1:0]    reg_write_data,
    output logic                 stage3_ready,
    output logic                 stage3_err
);

    stage3_state_e        state_q, state_d;
    op_t                  in_op;
    op_t                  act_op;
    logic                 pend_valid;
    logic                 push_c;
    logic                 pop_c;
    logic                 capture_c;
    logic                 timeout_c;
    logic                 ram_read_q;
    logic                 reg_we_q;
    logic [REG_IDX_W-1:0] reg_waddr_q;
    logic [DATA_W-1:0]    reg_wdata_q;
    logic                 ready_q;

    assign in_op.address  = stage3_read_address;
    assign in_op.dest_reg = stage3_dest_reg;
    assign push_c         = stage3_read && stage3_accept;
    assign pop_c          = (state_q == S3_WB);
    assign capture_c      = (state_q == S3_REQ) && stage3_ram_read_ready;

    stage3_op_buf u_op_buf (
        .clk_i        (ram_clk),
        .rst_i        (rst),
        .push_i       (push_c),
        .op_i         (in_op),
        .pop_i        (pop_c),
        .accept_o     (stage3_accept),
        .act_op_o     (act_op),
        .pend_valid_o (pend_valid)
    );

`ifdef STAGE3_MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q;

    // Counter only advances in REQ, so every entry to REQ starts from zero.
    always_comb begin
        cnt_d = '0;
        if (state_q == S3_REQ) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign timeout_c = (state_q == S3_REQ) && !stage3_ram_read_ready
                       && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge ram_clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (timeout_c) begin
                err_q <= 1'b1;
            end
        end
    end

    assign stage3_err = err_q;
`else
    logic [31:0] unused_timeout_cycles;

    assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
    assign timeout_c             = 1'b0;
    assign stage3_err            = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S3_IDLE: if (push_c) state_d = S3_REQ;
            S3_REQ:  if (capture_c || timeout_c) state_d = S3_WB;
            S3_WB:   state_d = (pend_valid || push_c) ? S3_REQ : S3_IDLE;
            default: state_d = S3_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge ram_clk or posedge rst) begin
        if (rst) begin
            state_q     <= S3_IDLE;
            ram_read_q  <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
            ready_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ram_read_q <= (state_d == S3_REQ);
            reg_we_q   <= capture_c;
            ready_q    <= (state_d == S3_WB);
            if (capture_c) begin
                reg_waddr_q <= act_op.dest_reg;
                reg_wdata_q <= stage3_ram_read_data_out;
            end
        end
    end

    assign stage3_ram_read         = ram_read_q;
    assign stage3_ram_read_address = act_op.address;
    assign reg_write_en            = reg_we_q;
    assign reg_write_addr          = reg_waddr_q;
    assign reg_write_data          = reg_wdata_q;
    assign stage3_ready            = ready_q;

endmodule

// File: tb/tb_stage3_mem.sv
// Directed self-checking bench for stage3_mem; the timeout scenario runs when STAGE3_MEM_TIMEOUT_EN is defined.
module tb_stage3_mem;
    import cpu_pkg::*;

`ifdef STAGE3_MEM_TIMEOUT_EN
    localparam int unsigned TO_CYCLES = 4;
`else
    localparam int unsigned TO_CYCLES = 64;
`endif

    logic                 ram_clk;
    logic                 rst;
    logic                 stage3_read;
    logic [ADDR_W-1:0]    stage3_read_address;
    logic [REG_IDX_W-1:0] stage3_dest_reg;
    logic                 stage3_accept;
    logic                 stage3_ram_read;
    logic [ADDR_W-1:0]    stage3_ram_read_address;
    logic                 stage3_ram_read_ready;
    logic [DATA_W-1:0]    stage3_ram_read_data_out;
    logic                 reg_write_en;
    logic [REG_IDX_W-1:0] reg_write_addr;
    logic [DATA_W-1:0]    reg_write_data;
    logic                 stage3_ready;
    logic                 stage3_err;

    int n_checks = 0;
    int n_errors = 0;

    stage3_mem #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
        .ram_clk                  (ram_clk),
        .rst                      (rst),
        .stage3_read              (stage3_read),
        .stage3_read_address      (stage3_read_address),
        .stage3_dest_reg          (stage3_dest_reg),
        .stage3_accept            (stage3_accept),
        .stage3_ram_read          (stage3_ram_read),
        .stage3_ram_read_address  (stage3_ram_read_address),
        .stage3_ram_read_ready    (stage3_ram_read_ready),
        .stage3_ram_read_data_out (stage3_ram_read_data_out),
        .reg_write_en             (reg_write_en),
        .reg_write_addr           (reg_write_addr),
        .reg_write_data           (reg_write_data),
        .stage3_ready             (stage3_ready),
        .stage3_err               (stage3_err)
    );

    initial ram_clk = 1'b0;
    always #5 ram_clk = ~ram_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ram_clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".we"},    32'(reg_write_en),    32'd0);
        check({tag, ".rdy"},   32'(stage3_ready),    32'd0);
        check({tag, ".rread"}, 32'(stage3_ram_read), 32'd0);
    endtask

    // Stream-test logs, indexed by cycle
    logic              rr_log  [16];
    logic              acc_log [16];
    logic              we_log  [16];
    logic [15:0]       ra_log  [16];
    logic [8:0]        wa_log  [16];
    logic [7:0]        wd_log  [16];

    initial begin
        logic [15:0] s_addr [3];
        logic [8:0]  s_dest [3];
        int k, j, req_run;
        logic acc_b, rd_b, rr_b, rdy_b;

        rst = 1'b1;
        stage3_read = 1'b0;
        stage3_read_address = '0;
        stage3_dest_reg = '0;
        stage3_ram_read_ready = 1'b0;
        stage3_ram_read_data_out = '0;
        #12;
        check("reset.accept", 32'(stage3_accept), 32'd1);
        check_quiet("reset");
        check("reset.err", 32'(stage3_err), 32'd0);
        check("reset.waddr", 32'(reg_write_addr), 32'd0);
        rst = 1'b0;
        tick();

        // Reset asserted in the middle of REQ
        stage3_read = 1'b1; stage3_read_address = 16'h0040; stage3_dest_reg = 9'd7;
        tick();
        stage3_read = 1'b0;
        check("midrst.req_before", 32'(stage3_ram_read), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst.req_drop", 32'(stage3_ram_read), 32'd0);
        check("midrst.accept", 32'(stage3_accept), 32'd1);
        #1 rst = 1'b0;
        stage3_ram_read_ready = 1'b1; stage3_ram_read_data_out = 8'hEE;
        tick();
        stage3_ram_read_ready = 1'b0;
        check_quiet("midrst.late1");
        tick();
        check_quiet("midrst.late2");

        // Single op, ready in the second request cycle
        stage3_read = 1'b1; stage3_read_address = 16'h0010; stage3_dest_reg = 9'd5;
        tick();
        stage3_read = 1'b0;
        check("single.req1", 32'(stage3_ram_read), 32'd1);
        check("single.addr", 32'(stage3_ram_read_address), 32'h0010);
        check("single.we_early", 32'(reg_write_en), 32'd0);
        tick();
        check("single.req2", 32'(stage3_ram_read), 32'd1);
        stage3_ram_read_ready = 1'b1; stage3_ram_read_data_out = 8'hA5;
        tick();
        stage3_ram_read_ready = 1'b0;
        check("single.we", 32'(reg_write_en), 32'd1);
        check("single.waddr", 32'(reg_write_addr), 32'd5);
        check("single.wdata", 32'(reg_write_data), 32'hA5);
        check("single.ready", 32'(stage3_ready), 32'd1);
        check("single.req_drop", 32'(stage3_ram_read), 32'd0);
        tick();
        check_quiet("single.after");

        // Three ops back-to-back, arbiter answers in the third request cycle
        s_addr[0] = 16'h0001; s_addr[1] = 16'h0002; s_addr[2] = 16'h0003;
        s_dest[0] = 9'd1;     s_dest[1] = 9'd2;     s_dest[2] = 9'd3;
        k = 0; j = 0; req_run = 0;
        for (int c = 0; c < 16; c++) begin
            rr_log[c]  = stage3_ram_read;
            acc_log[c] = stage3_accept;
            we_log[c]  = reg_write_en;
            ra_log[c]  = stage3_ram_read_address;
            wa_log[c]  = reg_write_addr;
            wd_log[c]  = reg_write_data;
            stage3_read = (k < 3);
            if (k < 3) begin
                stage3_read_address = s_addr[k];
                stage3_dest_reg     = s_dest[k];
            end
            stage3_ram_read_ready    = stage3_ram_read && (req_run == 2);
            stage3_ram_read_data_out = 8'hC1 + 8'(j);
            acc_b = stage3_accept; rd_b = stage3_read;
            rr_b  = stage3_ram_read; rdy_b = stage3_ram_read_ready;
            tick();
            if (rd_b && acc_b) k++;
            if (rr_b) req_run++;
            if (rdy_b) begin
                req_run = 0;
                j++;
            end
        end
        stage3_read = 1'b0;
        stage3_ram_read_ready = 1'b0;
        check("stream.acc_c1", 32'(acc_log[1]), 32'd1);
        check("stream.acc_c2", 32'(acc_log[2]), 32'd0);
        check("stream.acc_c4", 32'(acc_log[4]), 32'd0);
        check("stream.acc_c5", 32'(acc_log[5]), 32'd1);
        check("stream.acc_c6", 32'(acc_log[6]), 32'd0);
        check("stream.addr_c1", 32'(ra_log[1]), 32'h0001);
        check("stream.rr_c4", 32'(rr_log[4]), 32'd0);
        check("stream.rr_c5", 32'(rr_log[5]), 32'd1);
        check("stream.addr_c5", 32'(ra_log[5]), 32'h0002);
        check("stream.rr_c9", 32'(rr_log[9]), 32'd1);
        check("stream.addr_c9", 32'(ra_log[9]), 32'h0003);
        check("stream.we_c3", 32'(we_log[3]), 32'd0);
        check("stream.we_c4", 32'(we_log[4]), 32'd1);
        check("stream.wa_c4", 32'(wa_log[4]), 32'd1);
        check("stream.wd_c4", 32'(wd_log[4]), 32'hC1);
        check("stream.we_c8", 32'(we_log[8]), 32'd1);
        check("stream.wa_c8", 32'(wa_log[8]), 32'd2);
        check("stream.wd_c8", 32'(wd_log[8]), 32'hC2);
        check("stream.we_c12", 32'(we_log[12]), 32'd1);
        check("stream.wa_c12", 32'(wa_log[12]), 32'd3);
        check("stream.wd_c12", 32'(wd_log[12]), 32'hC3);
        check("stream.idle_c13", 32'(rr_log[13]), 32'd0);
        check("stream.k", 32'(k), 32'd3);

        // Spurious ready while IDLE
        stage3_ram_read_ready = 1'b1; stage3_ram_read_data_out = 8'h99;
        tick();
        check_quiet("spur.idle1");
        tick();
        stage3_ram_read_ready = 1'b0;
        check_quiet("spur.idle2");

        // Ready in the first REQ cycle and held through WB
        stage3_read = 1'b1; stage3_read_address = 16'h0020; stage3_dest_reg = 9'd9;
        tick();
        stage3_read = 1'b0;
        stage3_ram_read_ready = 1'b1; stage3_ram_read_data_out = 8'h3C;
        tick();
        check("spur.wb_we", 32'(reg_write_en), 32'd1);
        check("spur.wb_data", 32'(reg_write_data), 32'h3C);
        stage3_ram_read_data_out = 8'h77;
        tick();
        stage3_ram_read_ready = 1'b0;
        check_quiet("spur.after_wb");
        check("spur.data_kept", 32'(reg_write_data), 32'h3C);
        tick();
        check_quiet("spur.after_wb2");

        // Boundary: top address, top register, zero data
        stage3_read = 1'b1; stage3_read_address = 16'hFFFF; stage3_dest_reg = 9'd511;
        tick();
        stage3_read = 1'b0;
        check("bound.req", 32'(stage3_ram_read), 32'd1);
        check("bound.addr", 32'(stage3_ram_read_address), 32'hFFFF);
        stage3_ram_read_ready = 1'b1; stage3_ram_read_data_out = 8'h00;
        tick();
        stage3_ram_read_ready = 1'b0;
        check("bound.we", 32'(reg_write_en), 32'd1);
        check("bound.waddr", 32'(reg_write_addr), 32'd511);
        check("bound.wdata", 32'(reg_write_data), 32'h00);
        check("bound.ready", 32'(stage3_ready), 32'd1);
        tick();
        check_quiet("bound.after");

`ifdef STAGE3_MEM_TIMEOUT_EN
        // Arbiter never answers: abandon after TO_CYCLES request cycles
        stage3_read = 1'b1; stage3_read_address = 16'h0100; stage3_dest_reg = 9'd12;
        tick();
        stage3_read = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("to.req_held", 32'(stage3_ram_read), 32'd1);
            check("to.err_early", 32'(stage3_err), 32'd0);
            tick();
        end
        check("to.req_drop", 32'(stage3_ram_read), 32'd0);
        check("to.ready", 32'(stage3_ready), 32'd1);
        check("to.we", 32'(reg_write_en), 32'd0);
        check("to.err", 32'(stage3_err), 32'd1);
        tick();
        check("to.ready_once", 32'(stage3_ready), 32'd0);
        check("to.err_sticky", 32'(stage3_err), 32'd1);
        rst = 1'b1;
        #1;
        check("to.err_clear", 32'(stage3_err), 32'd0);
        rst = 1'b0;
        tick();
`else
        check("noto.err", 32'(stage3_err), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
